sky130_ef_sc_hd__decap_bank_ctrl: RTL and testbench



---
 rtl/sky130_ef_sc_hd__decap_bank_pkg.sv | 16 +
 rtl/sky130_ef_sc_hd__decap_step_timer.sv | 32 +++
 rtl/sky130_ef_sc_hd__decap_bank_ctrl.sv | 141 ++++++++++++++
 tb/tb_sky130_ef_sc_hd__decap_bank_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sky130_ef_sc_hd__decap_bank_pkg.sv
// Shared types for the decap bank sequencer: FSM state encoding and dwell width helper.
package sky130_ef_sc_hd__decap_bank_pkg;

    // Encoding is fixed so RAMP_DOWN keeps its code whether or not it is built.
    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } bank_state_t;

    function automatic int dwell_w(input int step_cycles);
        return ($clog2(step_cycles) < 1) ? 1 : $clog2(step_cycles);
    endfunction

endpackage

// File: rtl/sky130_ef_sc_hd__decap_step_timer.sv
// Dwell counter pacing segment transitions; tick marks the last cycle of a step.
module sky130_ef_sc_hd__decap_step_timer
    import sky130_ef_sc_hd__decap_bank_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET_B,
    input  logic clear,
    input  logic freeze,
    output logic tick
);

    localparam int DW = dwell_w(STEP_CYCLES);
    localparam logic [DW-1:0] LAST = DW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0] INC  = DW'(1);

    logic [DW-1:0] dwell;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            dwell <= '0;
        end else if (clear) begin
            dwell <= '0;
        end else if (!freeze) begin
            dwell <= (dwell == LAST) ? '0 : dwell + INC;
        end
    end

    assign tick = !freeze && (dwell == LAST);

endmodule

// File: rtl/sky130_ef_sc_hd__decap_bank_ctrl.sv
// Staggered enable sequencer for a bank of decap segments.
// Optional staggered disable: define SKY130_EF_DECAP_RAMPDOWN_EN.
module sky130_ef_sc_hd__decap_bank_ctrl
    import sky130_ef_sc_hd__decap_bank_pkg::*;
#(
    parameter int N_SEG       = 8,
    parameter int STEP_CYCLES = 4
) (
    input  logic                       CLK,
    input  logic                       RESET_B,
    input  logic                       EN,
    input  logic                       HOLD,
    output logic [N_SEG-1:0]           SEG_EN,
    output logic [$clog2(N_SEG+1)-1:0] LEVEL,
    output logic                       READY,
    output logic                       BUSY
);

    localparam int LW = $clog2(N_SEG + 1);
    localparam logic [LW-1:0] ONE = LW'(1);

    bank_state_t      state;
    logic             tick;
    logic             clear;
    logic [N_SEG-1:0] seg_up;

    assign seg_up = {SEG_EN[N_SEG-2:0], 1'b1};
`ifdef SKY130_EF_DECAP_RAMPDOWN_EN
    logic [N_SEG-1:0] seg_dn;
    assign seg_dn = {1'b0, SEG_EN[N_SEG-1:1]};
`endif

    // Dwell restarts whenever a ramp begins or reverses, and idles outside ramps.
    assign clear = !((state == RAMP_UP) || (state == RAMP_DOWN))
                 || ((state == RAMP_UP) && !EN)
                 || ((state == RAMP_DOWN) && EN);

    sky130_ef_sc_hd__decap_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .CLK    (CLK),
        .RESET_B(RESET_B),
        .clear  (clear),
        .freeze (HOLD),
        .tick   (tick)
    );

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state  <= OFF;
            SEG_EN <= '0;
            LEVEL  <= '0;
            READY  <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (EN) begin
                        SEG_EN <= {{(N_SEG-1){1'b0}}, 1'b1};
                        LEVEL  <= ONE;
                        state  <= RAMP_UP;
                        BUSY   <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!EN) begin
`ifdef SKY130_EF_DECAP_RAMPDOWN_EN
                        SEG_EN <= seg_dn;
                        LEVEL  <= LEVEL - ONE;
                        if (LEVEL == ONE) begin
                            state <= OFF;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= RAMP_DOWN;
                        end
`else
                        SEG_EN <= '0;
                        LEVEL  <= '0;
                        state  <= OFF;
                        BUSY   <= 1'b0;
`endif
                    end else if (tick) begin
                        SEG_EN <= seg_up;
                        LEVEL  <= LEVEL + ONE;
                        // Thermometer code: next-to-top bit set means this step fills the bank.
                        if (SEG_EN[N_SEG-2]) begin
                            state <= ON;
                            READY <= 1'b1;
                            BUSY  <= 1'b0;
                        end
                    end
                end
                ON: begin
                    if (!EN) begin
                        READY <= 1'b0;
`ifdef SKY130_EF_DECAP_RAMPDOWN_EN
                        SEG_EN <= seg_dn;
                        LEVEL  <= LEVEL - ONE;
                        state  <= RAMP_DOWN;
                        BUSY   <= 1'b1;
`else
                        SEG_EN <= '0;
                        LEVEL  <= '0;
                        state  <= OFF;
`endif
                    end
                end
`ifdef SKY130_EF_DECAP_RAMPDOWN_EN
                RAMP_DOWN: begin
                    if (EN) begin
                        SEG_EN <= seg_up;
                        LEVEL  <= LEVEL + ONE;
                        if (SEG_EN[N_SEG-2]) begin
                            state <= ON;
                            READY <= 1'b1;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= RAMP_UP;
                        end
                    end else if (tick) begin
                        SEG_EN <= seg_dn;
                        LEVEL  <= LEVEL - ONE;
                        if (LEVEL == ONE) begin
                            state <= OFF;
                            BUSY  <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state  <= OFF;
                    SEG_EN <= '0;
                    LEVEL  <= '0;
                    READY  <= 1'b0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sky130_ef_sc_hd__decap_bank_ctrl.sv
// Bench for the decap bank sequencer: default bank (8 seg, 4 cycles) and minimal bank (2 seg, 1 cycle).
module tb_sky130_ef_sc_hd__decap_bank_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_B;
    logic       EN;
    logic       HOLD;
    logic [7:0] seg_a;
    logic [3:0] lvl_a;
    logic       ready_a, busy_a;
    logic [1:0] seg_b;
    logic [1:0] lvl_b;
    logic       ready_b, busy_b;

    int checks = 0;
    int failures = 0;

    // Reference model: segment count, cycles spent at the current count, direction.
    int nseg [2] = '{8, 2};
    int stp  [2] = '{4, 1};
    int m_lvl[2];
    int m_cnt[2];
    bit m_down[2];

    always #5 CLK = ~CLK;

    sky130_ef_sc_hd__decap_bank_ctrl #(.N_SEG(8), .STEP_CYCLES(4)) dut_a (
        .CLK(CLK), .RESET_B(RESET_B), .EN(EN), .HOLD(HOLD),
        .SEG_EN(seg_a), .LEVEL(lvl_a), .READY(ready_a), .BUSY(busy_a)
    );

    sky130_ef_sc_hd__decap_bank_ctrl #(.N_SEG(2), .STEP_CYCLES(1)) dut_b (
        .CLK(CLK), .RESET_B(RESET_B), .EN(EN), .HOLD(HOLD),
        .SEG_EN(seg_b), .LEVEL(lvl_b), .READY(ready_b), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lvl[i]  = 0;
            m_cnt[i]  = 0;
            m_down[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic en, input logic hold);
        int n;
        int s;
        n = nseg[i];
        s = stp[i];
        if (en) begin
            if (m_lvl[i] == 0) begin
                m_lvl[i] = 1;
                m_cnt[i] = 0;
            end else if (m_lvl[i] == n) begin
                m_cnt[i] = 0;
            end else if (m_down[i]) begin
                m_lvl[i] = m_lvl[i] + 1;
                m_cnt[i] = 0;
            end else if (!hold) begin
                if (m_cnt[i] == s - 1) begin
                    m_lvl[i] = m_lvl[i] + 1;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_down[i] = 1'b0;
        end else begin
`ifdef SKY130_EF_DECAP_RAMPDOWN_EN
            if (m_lvl[i] > 0) begin
                if (!m_down[i]) begin
                    m_lvl[i] = m_lvl[i] - 1;
                    m_cnt[i] = 0;
                end else if (!hold) begin
                    if (m_cnt[i] == s - 1) begin
                        m_lvl[i] = m_lvl[i] - 1;
                        m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            m_down[i] = 1'b1;
`else
            m_lvl[i] = 0;
            m_cnt[i] = 0;
`endif
        end
    endtask

    task automatic check_all();
        int la;
        int lb;
        la = m_lvl[0];
        lb = m_lvl[1];
        chk("a_seg_en", 32'(seg_a), (32'd1 << la) - 32'd1);
        chk("a_level",  32'(lvl_a), 32'(la));
        chk("a_ready",  32'(ready_a), 32'(la == 8));
        chk("a_busy",   32'(busy_a), 32'((la > 0) && (la < 8)));
        chk("b_seg_en", 32'(seg_b), (32'd1 << lb) - 32'd1);
        chk("b_level",  32'(lvl_b), 32'(lb));
        chk("b_ready",  32'(ready_b), 32'(lb == 2));
        chk("b_busy",   32'(busy_b), 32'((lb > 0) && (lb < 2)));
    endtask

    task automatic edge_step();
        @(posedge CLK);
        for (int i = 0; i < 2; i++) model_step(i, EN, HOLD);
        #1;
        check_all();
    endtask

    task automatic go_off();
        int k;
        EN = 1'b0;
        HOLD = 1'b0;
        k = 0;
        while (((seg_a != 8'h00) || (seg_b != 2'b00)) && k < 100) begin
            edge_step();
            k++;
        end
        chk("go_off_bound", 32'(seg_a), 32'h0);
    endtask

    task automatic ramp_to(input logic [7:0] target);
        int k;
        EN = 1'b1;
        HOLD = 1'b0;
        k = 0;
        while (seg_a != target && k < 100) begin
            edge_step();
            k++;
        end
        chk("ramp_to_bound", 32'(seg_a), 32'(target));
    endtask

    task automatic reset_pulse();
        #1;
        RESET_B = 1'b0;
        #1;
        model_reset();
        chk("rst_seg_a", 32'(seg_a), 32'h0);
        chk("rst_lvl_a", 32'(lvl_a), 32'h0);
        chk("rst_rdy_a", 32'(ready_a), 32'h0);
        chk("rst_bsy_a", 32'(busy_a), 32'h0);
        chk("rst_seg_b", 32'(seg_b), 32'h0);
        #2;
        RESET_B = 1'b1;
    endtask

    initial begin
        int k;
        logic [7:0] held;
        RESET_B = 1'b0;
        EN = 1'b0;
        HOLD = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RESET_B = 1'b1;

        // Full ramp from OFF with fixed timing landmarks.
        EN = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            edge_step();
            if (e == 1) chk("a_first_seg", 32'(seg_a), 32'h01);
            if (e == 5) chk("a_second_seg", 32'(seg_a), 32'h03);
            if (e == 28) chk("a_not_ready_28", 32'(ready_a), 32'h0);
            if (e == 29) chk("a_full_29", 32'(seg_a), 32'hFF);
            if (e == 29) chk("a_ready_29", 32'(ready_a), 32'h1);
            if (e <= 28) chk("a_busy_ramp", 32'(busy_a), 32'h1);
            if (e == 1) chk("b_first_seg", 32'(seg_b), 32'h1);
            if (e == 2) chk("b_full_2", 32'(seg_b), 32'h3);
            if (e == 2) chk("b_ready_2", 32'(ready_b), 32'h1);
        end
        HOLD = 1'b1;
        edge_step();
        chk("on_hold_ignored", 32'(seg_a), 32'hFF);

        // Three HOLD cycles mid-ramp delay READY by three edges.
        go_off();
        EN = 1'b1;
        k = 0;
        repeat (10) begin edge_step(); k++; end
        held = seg_a;
        HOLD = 1'b1;
        repeat (3) begin
            edge_step();
            k++;
            chk("hold_frozen", 32'(seg_a), 32'(held));
        end
        HOLD = 1'b0;
        while (!ready_a && k < 100) begin edge_step(); k++; end
        chk("hold_ready_latency", 32'(k), 32'd32);

        // Disable part-way up the ramp.
        go_off();
        ramp_to(8'h0F);
        EN = 1'b0;
        edge_step();
`ifdef SKY130_EF_DECAP_RAMPDOWN_EN
        chk("fall_first", 32'(seg_a), 32'h07);
        k = 1;
        while (seg_a != 8'h00 && k < 100) begin edge_step(); k++; end
        chk("fall_done_edge", 32'(k), 32'd13);
        ramp_to(8'h0F);
        EN = 1'b0;
        edge_step();
        chk("redown_seg", 32'(seg_a), 32'h07);
        EN = 1'b1;
        edge_step();
        chk("rerise_seg", 32'(seg_a), 32'h0F);
        chk("rerise_busy", 32'(busy_a), 32'h1);
`else
        chk("fall_clear", 32'(seg_a), 32'h00);
`endif

        // Asynchronous reset mid-ramp, then restart with EN held.
        go_off();
        ramp_to(8'h3F);
        reset_pulse();
        edge_step();
        chk("restart_seg", 32'(seg_a), 32'h01);

        // Randomised EN/HOLD traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) EN = ~EN;
            HOLD = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) reset_pulse();
            edge_step();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
